rsa_modexp_sequencer: RTL and testbench
=======================================

Name: rsa_modexp_sequencer

Overview:
- Hardware sequencer for left-to-right square-and-multiply modular exponentiation. It walks the exponent bits itself, replacing the host-driven per-bit command loop.
- Sits between the CSR/command decoder and the Montgomery multiplier core.
- Issues one Montgomery operation at a time over a start/done handshake, then reports completion and operation counts.
- The multiplier core owns the operand storage (A accumulator, X message, R2, N). This block only selects the operation.

Parameters:
E_WIDTH, 32, maximum exponent width in bits (8..1024).
LEN_W, $clog2(E_WIDTH+1), width of the exponent-length field.
CNT_W, 11, width of the square/multiply counters.

Ports:
clk  in  1  system clock; all logic rising-edge.
resetn  in  1  asynchronous active-low reset.
start  in  1  single-cycle request; accepted only in IDLE.
abort  in  1  level; forces return to IDLE.
exp_in  in  E_WIDTH  exponent; sampled on the accepted start.
exp_len  in  LEN_W  number of significant exponent bits; sampled on the accepted start.
busy  out  1  high from the cycle after the accepted start until the return to IDLE.
done  out  1  sticky; set on normal completion, cleared by the next accepted start or by abort.
aborted  out  1  one-cycle pulse when an abort takes effect while busy.
mm_start  out  1  one-cycle pulse launching a multiplier operation.
mm_op  out  2  operation code, held stable from mm_start until mm_done: 0=SQR (A=A*A), 1=MUL (A=A*X), 2=OUT (A=A*1), 3=IN (X=X*R2).
mm_done  in  1  one-cycle completion pulse from the multiplier.
sqr_cnt  out  CNT_W  squares issued in the current or last run.
mul_cnt  out  CNT_W  multiplies issued in the current or last run.

Behaviour:
- Reset values: every output is 0. The state machine is in IDLE and the bit index is 0.
- Accepted start:
  - Latch exp_in and exp_len; clamp exp_len to E_WIDTH.
  - Clear done, sqr_cnt and mul_cnt.
  - Set the bit index to len-1.
- States: IDLE -> CONV_IN -> SQR -> MUL -> CONV_OUT -> FIN -> IDLE.
- Each operation state has an ISSUE sub-cycle and a WAIT sub-cycle:
  - ISSUE: mm_start=1 for exactly one cycle, with mm_op valid in the same cycle.
  - WAIT: hold until mm_done.
  - The minimum per-operation latency is 2 cycles (issue, then mm_done in the following cycle).
- Transitions:
  - CONV_IN -> SQR.
  - SQR done: if exp[idx]=1 -> MUL; otherwise idx==0 -> CONV_OUT, else idx-1 -> SQR.
  - MUL done: idx==0 -> CONV_OUT, else idx-1 -> SQR.
  - CONV_OUT done -> FIN.
  - FIN: set done, drop busy, go to IDLE (one cycle).
- exp_len==0 (after clamp): skip CONV_IN, SQR and MUL; go straight to CONV_OUT. The result is the A initial value (R mod N) converted out, i.e. 1.
- sqr_cnt increments on each SQR mm_start; mul_cnt increments on each MUL mm_start. Both saturate at all-ones.
- mm_done outside a WAIT sub-cycle is ignored.
- start while busy is ignored; the latched exponent is not disturbed.
- abort while busy:
  - Next cycle: IDLE, busy=0, done=0, aborted=1 for that cycle.
  - No further mm_start is issued; an outstanding mm_done is dropped.
  - Counters hold their values.
- abort in IDLE clears done, with no pulse.
- abort and start in the same cycle: abort wins, and start is not accepted.
- resetn low mid-run: immediate return to the reset values above.

Optional Feature:
- Macro: MODEXP_SKIP_LEADING_SQR_EN.
- Defined: a flag "acc_is_one" is set on start. While it is set, SQR states are bypassed: a zero bit goes straight to the next index, and a one bit goes straight to MUL.
  - The first MUL clears the flag.
  - sqr_cnt counts only the squares actually issued.
  - The final A value is identical to the non-skip case.
- Undefined: a square is issued for every bit, and acc_is_one logic is absent.

Test Plan:
- Reset: hold resetn=0 with start=1 -> all outputs 0; no mm_start while in reset.
- E=0x9985, len=16, mm_done returned 3 cycles after each mm_start:
  - Without macro: op stream IN, then 16 SQR interleaved with 7 MUL (first pair SQR,MUL), then OUT; sqr_cnt=16, mul_cnt=7, 25 mm_start pulses, done=1.
  - With macro: sqr_cnt=15, mul_cnt=7, 24 pulses, first op after IN is MUL.
- len=0, E=0xFFFF -> exactly one mm_start with mm_op=2; done=1; sqr_cnt=mul_cnt=0.
- len=40 with E_WIDTH=32 -> clamped to 32; sqr_cnt=32 without macro.
- abort asserted during the 5th WAIT -> aborted pulses once, busy=0 next cycle, done=0, no further mm_start even when the late mm_done arrives.
- start pulsed during a run, plus a spurious mm_done in an ISSUE cycle -> both ignored; op count and final counters match an undisturbed run.

Source files
------------

// File: rtl/rsa_modexp_sequencer.sv
// -----------------------------------------------------------------------------
// rsa_modexp_sequencer
// Left-to-right square-and-multiply sequencer for modular exponentiation.
// Walks the latched exponent from its most significant bit down to bit 0 and
// issues one Montgomery operation at a time to the multiplier core over an
// mm_start / mm_done handshake. The core owns all operands; this block only
// chooses which operation runs next and counts squares and multiplies.
//
// Operation order: IN (X=X*R2), then per exponent bit a SQR (A=A*A) followed by
// a MUL (A=A*X) when the bit is set, and finally OUT (A=A*1).
//
// Optional build macro: MODEXP_SKIP_LEADING_SQR_EN
//   When defined, squares are skipped while the accumulator still holds the
//   Montgomery form of 1 (before the first MUL), because squaring 1 is a no-op.
//
// Ports:
//   clk      - system clock, rising edge
//   resetn   - asynchronous active-low reset
//   start    - single-cycle request, accepted only in IDLE
//   abort    - level, forces a return to IDLE
//   exp_in   - exponent, sampled on the accepted start
//   exp_len  - significant exponent bits, sampled on the accepted start
//   busy     - high while a run is in progress
//   done     - sticky completion flag
//   aborted  - one-cycle pulse when an abort stops a run
//   mm_start - one-cycle launch pulse to the multiplier
//   mm_op    - operation code (0=SQR 1=MUL 2=OUT 3=IN), stable until mm_done
//   mm_done  - one-cycle completion pulse from the multiplier
//   sqr_cnt  - squares issued in the current or last run (saturating)
//   mul_cnt  - multiplies issued in the current or last run (saturating)
// -----------------------------------------------------------------------------
module rsa_modexp_sequencer #(
    parameter int E_WIDTH = 32,
    parameter int LEN_W   = $clog2(E_WIDTH + 1),
    parameter int CNT_W   = 11
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [E_WIDTH-1:0] exp_in,
    input  logic [LEN_W-1:0]   exp_len,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               mm_start,
    output logic [1:0]         mm_op,
    input  logic               mm_done,
    output logic [CNT_W-1:0]   sqr_cnt,
    output logic [CNT_W-1:0]   mul_cnt
);

    localparam int IDX_W = $clog2(E_WIDTH);

    localparam logic [1:0] OP_SQR = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_OUT = 2'd2;
    localparam logic [1:0] OP_IN  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CONV_IN  = 3'd1,
        S_SQR      = 3'd2,
        S_MUL      = 3'd3,
        S_CONV_OUT = 3'd4,
        S_FIN      = 3'd5
`ifdef MODEXP_SKIP_LEADING_SQR_EN
        ,
        S_SKIP     = 3'd6
`endif
    } state_t;

    state_t             state_r;
    logic               wait_r;       // 0: ISSUE sub-cycle, 1: WAIT sub-cycle
    logic [E_WIDTH-1:0] exp_r;
    logic [IDX_W-1:0]   idx_r;
    logic               busy_r;
    logic               done_r;
    logic               aborted_r;
    logic               mm_start_r;
    logic [1:0]         mm_op_r;
    logic [CNT_W-1:0]   sqr_cnt_r;
    logic [CNT_W-1:0]   mul_cnt_r;
`ifdef MODEXP_SKIP_LEADING_SQR_EN
    logic               acc_is_one_r;
`endif

    logic [LEN_W-1:0]   len_clamp_s;
    logic [IDX_W-1:0]   start_idx_s;
    logic               exp_bit_s;
    logic               idx_last_s;

    // Saturating increment for the operation counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Clamp the requested length to the exponent width and derive the first bit index.
    always_comb begin
        len_clamp_s = exp_len;
        start_idx_s = '0;
        if (exp_len > LEN_W'(E_WIDTH)) begin
            len_clamp_s = LEN_W'(E_WIDTH);
        end else begin
            len_clamp_s = exp_len;
        end
        if (len_clamp_s != '0) begin
            start_idx_s = IDX_W'(len_clamp_s - LEN_W'(1));
        end else begin
            start_idx_s = '0;
        end
    end

    // Decode the current exponent bit and whether it is the last one.
    always_comb begin
        exp_bit_s  = exp_r[idx_r];
        idx_last_s = (idx_r == '0);
    end

    // Sequencer FSM: operation selection, handshake, counters and status flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= S_IDLE;
            wait_r       <= 1'b0;
            exp_r        <= '0;
            idx_r        <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
            mm_start_r   <= 1'b0;
            mm_op_r      <= 2'd0;
            sqr_cnt_r    <= '0;
            mul_cnt_r    <= '0;
`ifdef MODEXP_SKIP_LEADING_SQR_EN
            acc_is_one_r <= 1'b0;
`endif
        end else begin
            aborted_r  <= 1'b0;
            mm_start_r <= 1'b0;
            if (abort) begin
                // Abort wins over everything; any outstanding mm_done is dropped
                // simply because IDLE never looks at it.
                aborted_r <= busy_r;
                state_r   <= S_IDLE;
                wait_r    <= 1'b0;
                busy_r    <= 1'b0;
                done_r    <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (start) begin
                            exp_r     <= exp_in;
                            idx_r     <= start_idx_s;
                            done_r    <= 1'b0;
                            sqr_cnt_r <= '0;
                            mul_cnt_r <= '0;
                            busy_r    <= 1'b1;
                            wait_r    <= 1'b0;
`ifdef MODEXP_SKIP_LEADING_SQR_EN
                            acc_is_one_r <= 1'b1;
`endif
                            mm_start_r <= 1'b1;
                            if (len_clamp_s == '0) begin
                                // Empty exponent: the result is 1, only convert out.
                                state_r <= S_CONV_OUT;
                                mm_op_r <= OP_OUT;
                            end else begin
                                state_r <= S_CONV_IN;
                                mm_op_r <= OP_IN;
                            end
                        end
                    end

                    S_CONV_IN: begin
                        if (!wait_r) begin
                            wait_r <= 1'b1;
                        end else if (mm_done) begin
                            wait_r <= 1'b0;
`ifdef MODEXP_SKIP_LEADING_SQR_EN
                            if (acc_is_one_r) begin
                                state_r <= S_SKIP;
                            end else begin
                                state_r    <= S_SQR;
                                mm_start_r <= 1'b1;
                                mm_op_r    <= OP_SQR;
                                sqr_cnt_r  <= sat_inc(sqr_cnt_r);
                            end
`else
                            state_r    <= S_SQR;
                            mm_start_r <= 1'b1;
                            mm_op_r    <= OP_SQR;
                            sqr_cnt_r  <= sat_inc(sqr_cnt_r);
`endif
                        end
                    end

                    S_SQR: begin
                        if (!wait_r) begin
                            wait_r <= 1'b1;
                        end else if (mm_done) begin
                            wait_r     <= 1'b0;
                            mm_start_r <= 1'b1;
                            if (exp_bit_s) begin
                                state_r   <= S_MUL;
                                mm_op_r   <= OP_MUL;
                                mul_cnt_r <= sat_inc(mul_cnt_r);
                            end else if (idx_last_s) begin
                                state_r <= S_CONV_OUT;
                                mm_op_r <= OP_OUT;
                            end else begin
                                idx_r     <= idx_r - IDX_W'(1);
                                state_r   <= S_SQR;
                                mm_op_r   <= OP_SQR;
                                sqr_cnt_r <= sat_inc(sqr_cnt_r);
                            end
                        end
                    end

                    S_MUL: begin
`ifdef MODEXP_SKIP_LEADING_SQR_EN
                        acc_is_one_r <= 1'b0;
`endif
                        if (!wait_r) begin
                            wait_r <= 1'b1;
                        end else if (mm_done) begin
                            wait_r     <= 1'b0;
                            mm_start_r <= 1'b1;
                            if (idx_last_s) begin
                                state_r <= S_CONV_OUT;
                                mm_op_r <= OP_OUT;
                            end else begin
                                idx_r     <= idx_r - IDX_W'(1);
                                state_r   <= S_SQR;
                                mm_op_r   <= OP_SQR;
                                sqr_cnt_r <= sat_inc(sqr_cnt_r);
                            end
                        end
                    end

`ifdef MODEXP_SKIP_LEADING_SQR_EN
                    // Bypassed square: the accumulator is still 1, so walk the
                    // leading zero bits without issuing anything.
                    S_SKIP: begin
                        if (exp_bit_s) begin
                            state_r    <= S_MUL;
                            mm_start_r <= 1'b1;
                            mm_op_r    <= OP_MUL;
                            mul_cnt_r  <= sat_inc(mul_cnt_r);
                        end else if (idx_last_s) begin
                            state_r    <= S_CONV_OUT;
                            mm_start_r <= 1'b1;
                            mm_op_r    <= OP_OUT;
                        end else begin
                            idx_r <= idx_r - IDX_W'(1);
                        end
                    end
`endif

                    S_CONV_OUT: begin
                        if (!wait_r) begin
                            wait_r <= 1'b1;
                        end else if (mm_done) begin
                            wait_r  <= 1'b0;
                            state_r <= S_FIN;
                        end
                    end

                    S_FIN: begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end

                    default: begin
                        state_r <= S_IDLE;
                        wait_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign aborted  = aborted_r;
    assign mm_start = mm_start_r;
    assign mm_op    = mm_op_r;
    assign sqr_cnt  = sqr_cnt_r;
    assign mul_cnt  = mul_cnt_r;

endmodule

// File: tb/tb_rsa_modexp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rsa_modexp_sequencer
// Self-checking bench for rsa_modexp_sequencer. A behavioural multiplier
// answers every mm_start after a programmable latency; expected operation codes
// are queued when a job is launched and compared as each mm_start appears.
// -----------------------------------------------------------------------------
module tb_rsa_modexp_sequencer;

    localparam int EW = 32;
    localparam int LW = 6;
    localparam int CW = 11;
`ifdef MODEXP_SKIP_LEADING_SQR_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          abort;
    logic [EW-1:0] exp_in;
    logic [LW-1:0] exp_len;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          mm_start;
    logic [1:0]    mm_op;
    logic          mm_done = 1'b0;
    logic [CW-1:0] sqr_cnt;
    logic [CW-1:0] mul_cnt;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];
    int         pulses   = 0;
    int         cd       = 0;
    int         lat      = 3;
    bit         spur_req = 1'b0;
    int         seen_sq  = 0;
    int         seen_mul = 0;
    logic [1:0] held_op  = 2'd0;

    rsa_modexp_sequencer #(.E_WIDTH(EW), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .exp_in(exp_in), .exp_len(exp_len), .busy(busy), .done(done),
        .aborted(aborted), .mm_start(mm_start), .mm_op(mm_op),
        .mm_done(mm_done), .sqr_cnt(sqr_cnt), .mul_cnt(mul_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Multiplier model and scoreboard consumer, sampled just after the edge.
    always @(posedge clk) begin
        logic [1:0] want;
        #1;
        mm_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) mm_done = 1'b1;
        end
        if (mm_start) begin
            pulses++;
            cd      = lat;
            held_op = mm_op;
            if (spur_req) begin
                mm_done  = 1'b1;   // lands in the ISSUE cycle, must be ignored
                spur_req = 1'b0;
            end
            check_val("op_avail", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check_val("mm_op", {30'd0, mm_op}, {30'd0, want});
                if (want == 2'd0) seen_sq++;
                if (want == 2'd1) seen_mul++;
            end
        end else if (mm_done && busy) begin
            check_val("op_hold", {30'd0, mm_op}, {30'd0, held_op});
        end
    end

    // Reference op stream for a job, pushed to the scoreboard.
    task automatic push_model(input logic [EW-1:0] e, input int len_req,
                              output int nsq, output int nmul);
        int len;
        bit one;
        len  = (len_req > EW) ? EW : len_req;
        one  = 1'b1;
        nsq  = 0;
        nmul = 0;
        if (len == 0) begin
            exp_q.push_back(2'd2);
        end else begin
            exp_q.push_back(2'd3);
            for (int i = len - 1; i >= 0; i--) begin
                if (!(SKIP && one)) begin
                    exp_q.push_back(2'd0);
                    nsq++;
                end
                if (e[i]) begin
                    exp_q.push_back(2'd1);
                    nmul++;
                    one = 1'b0;
                end
            end
            exp_q.push_back(2'd2);
        end
    endtask

    task automatic run_job(input logic [EW-1:0] e, input int len, input bit disturb);
        int  nsq, nmul, p0;
        bit  dist_done;
        push_model(e, len, nsq, nmul);
        p0        = pulses;
        dist_done = 1'b0;
        exp_in    = e;
        exp_len   = LW'(len);
        start     = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        exp_in = ~e;
        check_val("busy_rise", {31'd0, busy}, 32'd1);
        for (int c = 0; c < 3000 && !(done && !busy); c++) begin
            @(negedge clk);
            if (disturb && !dist_done && (pulses - p0) == 3) begin
                start     = 1'b1;
                exp_in    = '0;
                exp_len   = 6'd8;
                spur_req  = 1'b1;
                dist_done = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        check_val("finish", {31'd0, done && !busy}, 32'd1);
        check_val("sqr_cnt", {21'd0, sqr_cnt}, nsq);
        check_val("mul_cnt", {21'd0, mul_cnt}, nmul);
        check_val("pulses", pulses - p0, nsq + nmul + ((len == 0) ? 1 : 2));
        check_val("q_left", exp_q.size(), 0);
        @(negedge clk);
        check_val("done_sticky", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int nsq, nmul, p0, p1;
        resetn  = 1'b0;
        start   = 1'b1;
        abort   = 1'b0;
        exp_in  = 32'h0000_9985;
        exp_len = 6'd16;
        repeat (4) @(negedge clk);
        check_val("rst_outs", {4'd0, busy, done, aborted, mm_start, mm_op, sqr_cnt, mul_cnt}, 32'd0);
        check_val("rst_pulses", pulses, 0);
        start  = 1'b0;
        resetn = 1'b1;
        @(negedge clk);

        // Main example, then abort from IDLE clears sticky done without a pulse.
        run_job(32'h0000_9985, 16, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("idle_abort_done", {31'd0, done}, 32'd0);
        check_val("idle_abort_pulse", {31'd0, aborted}, 32'd0);

        // Abort and start together: abort wins.
        p0     = pulses;
        start  = 1'b1;
        abort  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        abort  = 1'b0;
        check_val("abort_start_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check_val("abort_start_pulses", pulses - p0, 0);

        run_job(32'h0000_FFFF, 0, 1'b0);
        run_job(32'hA5A5_0F0F, 40, 1'b0);
        lat = 1;
        run_job($urandom, 23, 1'b0);
        lat = 3;
        run_job(32'h0000_9985, 16, 1'b1);

        // Abort during the 5th WAIT.
        exp_q.delete();
        push_model(32'h0000_9985, 16, nsq, nmul);
        seen_sq  = 0;
        seen_mul = 0;
        p0       = pulses;
        exp_in   = 32'h0000_9985;
        exp_len  = 6'd16;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && (pulses - p0) < 5; c++) @(negedge clk);
        check_val("reach_5th", pulses - p0, 5);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("abort_pulse", {31'd0, aborted}, 32'd1);
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        check_val("abort_sqr", {21'd0, sqr_cnt}, seen_sq);
        check_val("abort_mul", {21'd0, mul_cnt}, seen_mul);
        exp_q.delete();
        p1 = pulses;
        @(negedge clk);
        check_val("abort_once", {31'd0, aborted}, 32'd0);
        repeat (8) @(negedge clk);
        check_val("abort_quiet", pulses - p1, 0);

        // Reset in the middle of a run.
        push_model(32'h0000_00F3, 8, nsq, nmul);
        exp_in  = 32'h0000_00F3;
        exp_len = 6'd8;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_val("midrst_outs", {4'd0, busy, done, aborted, mm_start, mm_op, sqr_cnt, mul_cnt}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        p1 = pulses;
        repeat (6) @(negedge clk);
        check_val("midrst_quiet", pulses - p1, 0);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
